// File: rtl/ring_traffic_injector_if.sv
// Local-port handshake between a ring traffic injector and its router.
interface ring_traffic_injector_if #(
    parameter int PACKET_SIZE = 49
);
    logic [PACKET_SIZE-1:0] pkt_out;
    logic                   pkt_valid;
    logic                   pkt_ready;

    modport master (output pkt_out, output pkt_valid, input pkt_ready);
    modport slave  (input pkt_out, input pkt_valid, output pkt_ready);
endinterface

// File: rtl/ring_traffic_injector.sv
// Synthetic traffic source for one ring node: builds packets on injection slots,
// buffers them in a small FIFO and offers them to the router local port.
module ring_traffic_injector #(
    parameter int NUM_NODES            = 8,
    parameter int ROUTER_ID            = 0,
    parameter int PACKET_SIZE          = 49,
    parameter int BUFFER_SIZE          = 4,
    parameter int NUM_PACKETS_PER_NODE = 20,
    parameter int TRAFFIC_PATTERN      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             clk_counter,
    input  logic [15:0]             inject_clk_ref,
    ring_traffic_injector_if.master pkt_if,
    output logic [63:0]             total_packet_sent,
    output logic [63:0]             total_inject_blocked,
    output logic                    done
);
    typedef enum logic [1:0] {GEN, DRAIN, DONE} state_t;

    localparam int             PTR_W     = $clog2(BUFFER_SIZE);
    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(BUFFER_SIZE);
    localparam logic [15:0]    NODES16   = 16'(NUM_NODES);
    localparam logic [15:0]    ID16      = 16'(ROUTER_ID);
    localparam logic [15:0]    TARGET    = 16'(NUM_PACKETS_PER_NODE);
    localparam logic [15:0]    SUM_NEIGH = ID16 + 16'd1;
    localparam logic [15:0]    SUM_TORN  = ID16 + (NODES16 >> 1);
    // Destination is fixed per instance; sums wrap at 16 bits before the modulo.
    localparam logic [15:0]    DEST      = (TRAFFIC_PATTERN == 1) ? (SUM_NEIGH % NODES16) :
                                           (TRAFFIC_PATTERN == 2) ? (SUM_TORN % NODES16) :
                                           (NODES16 - 16'd1 - ID16);
    localparam logic           SELF_DEST = (DEST == ID16);
    localparam state_t         RST_STATE = (NUM_PACKETS_PER_NODE == 0) ? DRAIN : GEN;

    state_t                 state, state_next;
    logic [PACKET_SIZE-1:0] mem [BUFFER_SIZE];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [PTR_W:0]         count;
    logic [15:0]            gen_cnt;
    logic                   attempt, full, gen_inc, push, pop, not_empty;
    logic [PACKET_SIZE-1:0] new_pkt;

    assign not_empty = (count != '0);
    assign full      = (count == FULL_CNT);
    assign attempt   = (state == GEN) && (inject_clk_ref == 16'd0);
    assign gen_inc   = attempt && !full;
    assign push      = gen_inc && !SELF_DEST;
    assign pop       = not_empty && pkt_if.pkt_ready;
    assign new_pkt   = {1'b1, clk_counter, ID16, DEST};

    assign pkt_if.pkt_valid = not_empty;
    assign pkt_if.pkt_out   = not_empty ? mem[rd_ptr] : '0;
    assign done             = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RST_STATE;
        else        state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            GEN:     if (gen_inc && ((gen_cnt + 16'd1) == TARGET)) state_next = DRAIN;
            DRAIN:   if (!not_empty) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = RST_STATE;
        endcase
    end

    // NOTE: packet storage has no reset; pkt_out is masked by the occupancy count instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_pkt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            count                <= '0;
            gen_cnt              <= '0;
            total_packet_sent    <= '0;
            total_inject_blocked <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr            <= rd_ptr + 1'b1;
                total_packet_sent <= total_packet_sent + 64'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (gen_inc) gen_cnt <= gen_cnt + 16'd1;
            // The full test uses the registered count, so a same-cycle pop still blocks.
            if (attempt && full) total_inject_blocked <= total_inject_blocked + 64'd1;
        end
    end
endmodule

// File: tb/tb_ring_traffic_injector.sv
// Directed bench: a cycle table for stall/release/push-pop on one node, plus
// sequences for reset, full run, self-traffic, zero-packet and other patterns.
module tb_ring_traffic_injector;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, rst_n_o;
    logic [15:0] clk_cnt, inj;
    int          total = 0;
    int          bad = 0;

    logic [63:0] sent_a, blk_a, sent_b, blk_b, sent_c, blk_c, sent_d, blk_d, sent_e, blk_e;
    logic        done_a, done_b, done_c, done_d, done_e;

    ring_traffic_injector_if #(.PACKET_SIZE(49)) if_a ();
    ring_traffic_injector_if #(.PACKET_SIZE(49)) if_b ();
    ring_traffic_injector_if #(.PACKET_SIZE(49)) if_c ();
    ring_traffic_injector_if #(.PACKET_SIZE(49)) if_d ();
    ring_traffic_injector_if #(.PACKET_SIZE(49)) if_e ();

    ring_traffic_injector #(.NUM_NODES(8), .ROUTER_ID(2), .TRAFFIC_PATTERN(0)) u_a (
        .clk(clk), .rst_n(rst_n_a), .clk_counter(clk_cnt), .inject_clk_ref(inj), .pkt_if(if_a),
        .total_packet_sent(sent_a), .total_inject_blocked(blk_a), .done(done_a));
    ring_traffic_injector #(.NUM_NODES(9), .ROUTER_ID(4), .TRAFFIC_PATTERN(0)) u_b (
        .clk(clk), .rst_n(rst_n_o), .clk_counter(clk_cnt), .inject_clk_ref(inj), .pkt_if(if_b),
        .total_packet_sent(sent_b), .total_inject_blocked(blk_b), .done(done_b));
    ring_traffic_injector #(.NUM_NODES(8), .ROUTER_ID(1), .NUM_PACKETS_PER_NODE(0)) u_c (
        .clk(clk), .rst_n(rst_n_o), .clk_counter(clk_cnt), .inject_clk_ref(inj), .pkt_if(if_c),
        .total_packet_sent(sent_c), .total_inject_blocked(blk_c), .done(done_c));
    ring_traffic_injector #(.NUM_NODES(8), .ROUTER_ID(7), .TRAFFIC_PATTERN(1),
                            .NUM_PACKETS_PER_NODE(2)) u_d (
        .clk(clk), .rst_n(rst_n_o), .clk_counter(clk_cnt), .inject_clk_ref(inj), .pkt_if(if_d),
        .total_packet_sent(sent_d), .total_inject_blocked(blk_d), .done(done_d));
    ring_traffic_injector #(.NUM_NODES(8), .ROUTER_ID(5), .TRAFFIC_PATTERN(2), .BUFFER_SIZE(2),
                            .NUM_PACKETS_PER_NODE(2)) u_e (
        .clk(clk), .rst_n(rst_n_o), .clk_counter(clk_cnt), .inject_clk_ref(inj), .pkt_if(if_e),
        .total_packet_sent(sent_e), .total_inject_blocked(blk_e), .done(done_e));

    typedef struct {
        logic        inj_zero;
        logic        ready;
        logic        exp_valid;
        logic [15:0] exp_ts;
        logic [63:0] exp_blk;
        logic [63:0] exp_sent;
    } vec_t;

    vec_t        vecs [19];
    logic [48:0] got_a [$];
    logic [15:0] slot_ts [$];
    logic        collect_a = 1'b0;
    logic        b_ever_valid = 1'b0;
    logic        c_ever_valid = 1'b0;
    int          d_seen = 0;
    int          e_seen = 0;
    logic [48:0] d_last = '0;
    logic [48:0] e_last = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observe pre-edge outputs (a transfer happens at the coming edge), then advance one cycle.
    task automatic step();
        if (collect_a && if_a.pkt_valid && if_a.pkt_ready) got_a.push_back(if_a.pkt_out);
        if (if_b.pkt_valid) b_ever_valid = 1'b1;
        if (if_c.pkt_valid) c_ever_valid = 1'b1;
        if (if_d.pkt_valid) begin d_seen++; d_last = if_d.pkt_out; end
        if (if_e.pkt_valid) begin e_seen++; e_last = if_e.pkt_out; end
        @(posedge clk);
        #1;
        clk_cnt = clk_cnt + 16'd1;
    endtask

    function automatic vec_t mk(input logic iz, input logic rd, input logic ev,
                                input logic [15:0] ts, input logic [63:0] blk,
                                input logic [63:0] snt);
        vec_t v;
        v.inj_zero  = iz;
        v.ready     = rd;
        v.exp_valid = ev;
        v.exp_ts    = ts;
        v.exp_blk   = blk;
        v.exp_sent  = snt;
        return v;
    endfunction

    initial begin
        logic [48:0] exp_pkt;

        // Rows 0..11: slot every cycle with the router stalled; 4 fill, 8 are blocked.
        for (int r = 0; r < 12; r++)
            vecs[r] = mk(1'b1, 1'b0, 1'b1, 16'd100, (r < 4) ? 64'd0 : 64'(r - 3), 64'd0);
        vecs[12] = mk(1'b0, 1'b1, 1'b1, 16'd101, 64'd8, 64'd1);
        vecs[13] = mk(1'b0, 1'b1, 1'b1, 16'd102, 64'd8, 64'd2);
        vecs[14] = mk(1'b1, 1'b1, 1'b1, 16'd103, 64'd8, 64'd3); // push+pop at count 2
        vecs[15] = mk(1'b1, 1'b1, 1'b1, 16'd114, 64'd8, 64'd4); // push+pop at count 2
        vecs[16] = mk(1'b0, 1'b1, 1'b1, 16'd115, 64'd8, 64'd5);
        vecs[17] = mk(1'b0, 1'b1, 1'b0, 16'd0,   64'd8, 64'd6);
        vecs[18] = mk(1'b0, 1'b0, 1'b0, 16'd0,   64'd8, 64'd6);

        rst_n_a = 1'b0;
        rst_n_o = 1'b0;
        clk_cnt = 16'd0;
        inj     = 16'd1;
        if_a.pkt_ready = 1'b0;
        if_b.pkt_ready = 1'b1;
        if_c.pkt_ready = 1'b1;
        if_d.pkt_ready = 1'b1;
        if_e.pkt_ready = 1'b1;
        #1;
        check("rst_valid", 64'(if_a.pkt_valid), 64'd0);
        check("rst_pkt", 64'(if_a.pkt_out), 64'd0);
        check("rst_sent", sent_a, 64'd0);
        check("rst_blocked", blk_a, 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_done_zero_pkts", 64'(done_c), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n_a = 1'b1;
        rst_n_o = 1'b1;
        #1;
        check("zero_pkts_done_cycle1", 64'(done_c), 64'd0);
        step();
        check("zero_pkts_done_cycle2", 64'(done_c), 64'd1);

        // Stall, blocked slots, release and same-cycle push/pop.
        clk_cnt = 16'd100;
        for (int r = 0; r < 19; r++) begin
            inj = vecs[r].inj_zero ? 16'd0 : 16'd1;
            if_a.pkt_ready = vecs[r].ready;
            step();
            exp_pkt = vecs[r].exp_valid ? {1'b1, vecs[r].exp_ts, 16'd2, 16'd5} : 49'd0;
            check($sformatf("row%0d_valid", r), 64'(if_a.pkt_valid), 64'(vecs[r].exp_valid));
            check($sformatf("row%0d_pkt", r), 64'(if_a.pkt_out), 64'(exp_pkt));
            check($sformatf("row%0d_blocked", r), blk_a, vecs[r].exp_blk);
            check($sformatf("row%0d_sent", r), sent_a, vecs[r].exp_sent);
        end

        // Queue three packets, then reset mid-operation.
        inj = 16'd0;
        if_a.pkt_ready = 1'b0;
        repeat (3) step();
        inj = 16'd1;
        check("pre_reset_valid", 64'(if_a.pkt_valid), 64'd1);
        check("pre_reset_sent", sent_a, 64'd6);
        rst_n_a = 1'b0;
        #1;
        check("midrst_valid", 64'(if_a.pkt_valid), 64'd0);
        check("midrst_pkt", 64'(if_a.pkt_out), 64'd0);
        check("midrst_sent", sent_a, 64'd0);
        check("midrst_blocked", blk_a, 64'd0);
        check("midrst_done", 64'(done_a), 64'd0);
        @(negedge clk);
        rst_n_a = 1'b1;

        // Full run: slot every 2 cycles, router always ready, 20 packets from a fresh count.
        collect_a = 1'b1;
        if_a.pkt_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (k % 2 == 0) begin
                inj = 16'd0;
                slot_ts.push_back(clk_cnt);
            end else begin
                inj = 16'd1;
            end
            step();
        end
        inj = 16'd1;
        repeat (3) step();
        collect_a = 1'b0;

        check("run_pkt_count", 64'(got_a.size()), 64'd20);
        for (int i = 0; i < 20 && i < got_a.size(); i++)
            check($sformatf("run_pkt%0d", i), 64'(got_a[i]), 64'({1'b1, slot_ts[i], 16'd2, 16'd5}));
        check("run_sent", sent_a, 64'd20);
        check("run_blocked", blk_a, 64'd0);
        check("run_done", 64'(done_a), 64'd1);
        check("run_valid_end", 64'(if_a.pkt_valid), 64'd0);

        check("self_never_valid", 64'(b_ever_valid), 64'd0);
        check("self_done", 64'(done_b), 64'd1);
        check("self_sent", sent_b, 64'd0);
        check("self_blocked", blk_b, 64'd0);

        check("zero_pkts_never_valid", 64'(c_ever_valid), 64'd0);
        check("zero_pkts_done_end", 64'(done_c), 64'd1);

        check("neigh_seen", 64'(d_seen), 64'd2);
        check("neigh_dest", 64'(d_last[15:0]), 64'd0);
        check("neigh_src", 64'(d_last[31:16]), 64'd7);
        check("neigh_sent", sent_d, 64'd2);
        check("neigh_done", 64'(done_d), 64'd1);

        check("tornado_seen", 64'(e_seen), 64'd2);
        check("tornado_dest", 64'(e_last[15:0]), 64'd1);
        check("tornado_src", 64'(e_last[31:16]), 64'd5);
        check("tornado_sent", sent_e, 64'd2);
        check("tornado_done", 64'(done_e), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ring_traffic_injector.md
RING_TRAFFIC_INJECTOR -- requirements
Module: ring_traffic_injector

Interface
REQ-001 Parameter NUM_NODES, default 8: ring node count, 2..65535.
REQ-002 Parameter ROUTER_ID, default 0: this node's index, 0..NUM_NODES-1.
REQ-003 Parameter PACKET_SIZE, default 49: packet width, fixed at 49.
REQ-004 Parameter BUFFER_SIZE, default 4: source-queue depth, power of two, at least 2.
REQ-005 Parameter NUM_PACKETS_PER_NODE, default 20: number of packets to generate, 0..65535.
REQ-006 Parameter TRAFFIC_PATTERN, default 0: 0 = bit complement, 1 = neighbour, 2 = tornado.
REQ-007 Port clk, input, 1 bit: the only clock; all logic updates on the rising edge.
REQ-008 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port clk_counter, input, 16 bits: global cycle count, used as the timestamp source.
REQ-010 Port inject_clk_ref, input, 16 bits: injection phase; the value 0 marks an injection slot.
REQ-011 Port pkt_out, output, PACKET_SIZE bits: packet offered to the router local input.
REQ-012 Port pkt_valid, output, 1 bit: pkt_out holds a valid packet.
REQ-013 Port pkt_ready, input, 1 bit: router accepts the packet this cycle.
REQ-014 Port total_packet_sent, output, 64 bits: count of accepted packets.
REQ-015 Port total_inject_blocked, output, 64 bits: count of injection slots lost because the queue was full.
REQ-016 Port done, output, 1 bit: all packets have been generated and the queue is empty.

Function
REQ-017 Packet layout, MSB first, SHALL be {valid[48], timestamp[47:32], source[31:16], destination[15:0]}:
- source = ROUTER_ID.
- timestamp = clk_counter sampled in the generation cycle.
REQ-018 Destination SHALL be selected by TRAFFIC_PATTERN:
- pattern 0: (NUM_NODES-1)-ROUTER_ID.
- pattern 1: (ROUTER_ID+1) mod NUM_NODES.
- pattern 2: (ROUTER_ID+NUM_NODES/2) mod NUM_NODES.
- All arithmetic is 16-bit.
REQ-019 A generation attempt SHALL occur in any cycle where state = GEN and inject_clk_ref == 0.
REQ-020 An attempt with queue count < BUFFER_SIZE SHALL:
- push the packet into the queue;
- increment the 16-bit generated counter.
REQ-021 An attempt with queue count == BUFFER_SIZE SHALL:
- push nothing and leave the generated counter unchanged;
- increment total_inject_blocked.
- The full check uses the registered count, so a pop in the same cycle does not unblock the push.
REQ-022 If the computed destination equals ROUTER_ID, the attempt SHALL:
- push nothing;
- still increment the generated counter (self-traffic is discarded, not retried).
REQ-023 pkt_valid SHALL equal "queue not empty"; pkt_out SHALL equal the queue head when valid and all zeros otherwise.
REQ-024 A packet pushed at rising edge E SHALL be visible on pkt_out in the cycle after E, when the queue was empty (latency 1).
REQ-025 A transfer SHALL occur when pkt_valid and pkt_ready are both high at a rising edge; it pops the head and increments total_packet_sent.
REQ-026 While pkt_valid=1 and pkt_ready=0, pkt_out SHALL hold stable.
REQ-027 A simultaneous push and pop SHALL leave the queue count unchanged and keep FIFO order; pointers wrap modulo BUFFER_SIZE.
REQ-028 The FSM SHALL have states GEN, DRAIN and DONE:
- GEN→DRAIN when the generated counter reaches NUM_PACKETS_PER_NODE;
- DRAIN→DONE when the queue is empty;
- DONE is terminal until reset.
REQ-029 done SHALL be 1 only in DONE; no attempts occur in DRAIN or DONE.
REQ-030 If NUM_PACKETS_PER_NODE = 0, the state after reset SHALL be DRAIN, with done=1 one cycle later.
REQ-031 The 64-bit counters SHALL wrap modulo 2^64 with no saturation.

Reset
REQ-032 While rst_n=0, the block SHALL immediately hold:
- state = GEN, or DRAIN per REQ-030;
- queue empty, pointers and generated counter 0;
- pkt_valid=0 and pkt_out=0;
- total_packet_sent=0, total_inject_blocked=0, done=0.
REQ-033 Reset asserted mid-operation SHALL discard queued packets, which are not counted as sent.

Verification
REQ-034 Bench SHALL cover:
- N=8, ID=2, pattern 0, pkt_ready=1, slot every 2 cycles, 20 packets → 20 packets, each with dest=5 and src=2, timestamps increasing by 2; total_packet_sent=20; done=1; total_inject_blocked=0.
- BUFFER_SIZE=4, pkt_ready=0 for 12 slots → queue holds 4 packets and total_inject_blocked=8; pkt_out stays stable; then release ready → FIFO order is preserved and the timestamps match the first 4 slots.
- Push and pop in the same cycle at count=2 → count stays 2 and the output sequence is unbroken.
- N=9, ID=4, pattern 0 (dest=self) → nothing pushed; pkt_valid never 1; done=1 after 20 slots; total_packet_sent=0.
- Assert rst_n low with 3 packets queued → the same cycle shows pkt_valid=0 and counters 0; after release, generation restarts from 0.
- NUM_PACKETS_PER_NODE=0 → done=1 in the second cycle after reset release; pkt_valid never 1.
